// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps walk/ping-pong/binary patterns on rising edges of a divided tick.
// Optional ping-pong mode is enabled with `define LED_SEQ_PINGPONG_EN (otherwise mode 10 = walk-left).
module led_pattern_seq #(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_slow,
  input  logic             tick_fast,
  input  logic             speed_sel,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic [7:0]       step_count,
  output logic             wrap
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [1:0] MODE_WL  = 2'b00;
  localparam logic [1:0] MODE_WR  = 2'b01;
  localparam logic [1:0] MODE_BIN = 2'b11;
`ifdef LED_SEQ_PINGPONG_EN
  localparam logic [1:0] MODE_PP  = 2'b10;
`endif

  localparam logic [LED_W-1:0] LED_ZERO = '0;
  localparam logic [LED_W-1:0] LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB  = {1'b1, {(LED_W-1){1'b0}}};

  logic             slow_q;
  logic             fast_q;
  logic [1:0]       mode_q;
  state_t           state;
  logic             sel_tick;
  logic             sel_q;
  logic             step;
  logic             mode_chg;
  logic [LED_W-1:0] seed;
  logic [LED_W-1:0] led_nxt;
  logic             wrap_nxt;
`ifdef LED_SEQ_PINGPONG_EN
  logic             dir_left;
  logic             dir_nxt;
  logic             pp_left;
`endif

  function automatic logic [LED_W-1:0] rot_left(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

  function automatic logic [LED_W-1:0] rot_right(input logic [LED_W-1:0] v);
    return {v[0], v[LED_W-1:1]};
  endfunction

  // Each tick keeps its own history, so switching speed_sel compares a tick
  // only against its own previous sample and cannot fabricate an edge.
  assign sel_tick = speed_sel ? tick_fast : tick_slow;
  assign sel_q    = speed_sel ? fast_q    : slow_q;
  assign step     = sel_tick & ~sel_q & ~pause;
  assign mode_chg = (mode != mode_q);

  always_comb begin
    case (mode)
      MODE_WR:  seed = LED_MSB;
      MODE_BIN: seed = LED_ZERO;
      default:  seed = LED_ONE;
    endcase
  end

  always_comb begin
    led_nxt  = led;
    wrap_nxt = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
    dir_nxt  = dir_left;
    pp_left  = dir_left;
`endif
    case (mode_q)
      MODE_WR: begin
        led_nxt  = rot_right(led);
        wrap_nxt = led[0];
      end
      MODE_BIN: begin
        led_nxt  = led + LED_ONE;
        wrap_nxt = &led;
      end
`ifdef LED_SEQ_PINGPONG_EN
      MODE_PP: begin
        // Bounce off the ends: LSB forces left, MSB forces right.
        pp_left = led[0] | (dir_left & ~led[LED_W-1]);
        led_nxt = pp_left ? (led << 1) : (led >> 1);
        if (led_nxt[0]) begin
          dir_nxt  = 1'b1;
          wrap_nxt = 1'b1;
        end else if (led_nxt[LED_W-1]) begin
          dir_nxt  = 1'b0;
        end else begin
          dir_nxt  = pp_left;
        end
      end
`endif
      default: begin
        led_nxt  = rot_left(led);
        wrap_nxt = led[LED_W-1];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slow_q     <= 1'b0;
      fast_q     <= 1'b0;
      mode_q     <= MODE_WL;
      state      <= RUN;
      led        <= LED_ONE;
      step_count <= 8'd0;
      wrap       <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
      dir_left   <= 1'b1;
`endif
    end else begin
      slow_q <= tick_slow;
      fast_q <= tick_fast;
      wrap   <= 1'b0;
      case (state)
        RUN:     if (pause)  state <= HOLD;
        HOLD:    if (!pause) state <= RUN;
        default: state <= RUN;
      endcase
      // A mode change takes priority and swallows any coincident step.
      if (mode_chg) begin
        led        <= seed;
        step_count <= 8'd0;
        mode_q     <= mode;
`ifdef LED_SEQ_PINGPONG_EN
        dir_left   <= 1'b1;
`endif
      end else if (step) begin
        led        <= led_nxt;
        wrap       <= wrap_nxt;
        step_count <= step_count + 8'd1;
`ifdef LED_SEQ_PINGPONG_EN
        dir_left   <= dir_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: table of pulse runs plus hand-written corner sequences.
module tb_led_pattern_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_slow;
  logic       tick_fast;
  logic       speed_sel;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] led;
  logic [7:0] step_count;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int wrap_cnt = 0;

  typedef struct {
    logic [1:0] mode;
    logic       ss;
    int         n;
    logic [7:0] led;
    logic [7:0] cnt;
    int         wraps;
  } vec_t;

  vec_t vecs[11];

  led_pattern_seq #(.LED_W(8)) dut (
    .clk(clk), .rst(rst), .tick_slow(tick_slow), .tick_fast(tick_fast),
    .speed_sel(speed_sel), .mode(mode), .pause(pause),
    .led(led), .step_count(step_count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic fast);
    @(negedge clk);
    if (fast) tick_fast = 1'b1; else tick_slow = 1'b1;
    repeat (2) @(negedge clk);
    if (fast) tick_fast = 1'b0; else tick_slow = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 8,   8'h01, 8'd8,   1};
    vecs[1] = '{2'b00, 1'b1, 3,   8'h08, 8'd11,  0};
    vecs[2] = '{2'b01, 1'b0, 1,   8'h40, 8'd1,   0};
    vecs[3] = '{2'b01, 1'b0, 6,   8'h01, 8'd7,   0};
    vecs[4] = '{2'b01, 1'b0, 1,   8'h80, 8'd8,   1};
`ifdef LED_SEQ_PINGPONG_EN
    vecs[5] = '{2'b10, 1'b0, 13,  8'h02, 8'd13,  0};
    vecs[6] = '{2'b10, 1'b0, 1,   8'h01, 8'd14,  1};
    vecs[7] = '{2'b10, 1'b0, 1,   8'h02, 8'd15,  0};
`else
    vecs[5] = '{2'b10, 1'b0, 13,  8'h20, 8'd13,  1};
    vecs[6] = '{2'b10, 1'b0, 1,   8'h40, 8'd14,  0};
    vecs[7] = '{2'b10, 1'b0, 1,   8'h80, 8'd15,  0};
`endif
    vecs[8]  = '{2'b11, 1'b0, 255, 8'hFF, 8'd255, 0};
    vecs[9]  = '{2'b11, 1'b0, 1,   8'h00, 8'd0,   1};
    vecs[10] = '{2'b11, 1'b1, 5,   8'h05, 8'd5,   0};

    rst = 1'b0; tick_slow = 1'b0; tick_fast = 1'b0;
    speed_sel = 1'b0; mode = 2'b00; pause = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_led", led, 8'h01);
    chk("reset_cnt", step_count, 8'd0);
    chk("reset_wrap", wrap, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mode = vecs[i].mode;
      speed_sel = vecs[i].ss;
      @(negedge clk);
      wrap_cnt = 0;
      repeat (vecs[i].n) pulse(vecs[i].ss);
      chk($sformatf("vec%0d_led", i), led, vecs[i].led);
      chk($sformatf("vec%0d_cnt", i), step_count, vecs[i].cnt);
      chk($sformatf("vec%0d_wraps", i), wrap_cnt, vecs[i].wraps);
    end

    // Pause discards edges
    @(negedge clk); speed_sel = 1'b0; pause = 1'b1;
    repeat (3) pulse(1'b0);
    pause = 1'b0;
    @(negedge clk);
    chk("pause_led", led, 8'h05);
    chk("pause_cnt", step_count, 8'd5);
    pulse(1'b0);
    chk("unpause_led", led, 8'h06);
    chk("unpause_cnt", step_count, 8'd6);

    // Reload while paused
    pause = 1'b1; mode = 2'b00;
    @(negedge clk);
    chk("pause_reload_led", led, 8'h01);
    chk("pause_reload_cnt", step_count, 8'd0);
    pause = 1'b0;
    @(negedge clk);
    pulse(1'b0);
    chk("after_reload_led", led, 8'h02);

    // Mode change coincident with a tick edge drops the step
    mode = 2'b01; tick_slow = 1'b1;
    @(negedge clk);
    chk("coinc_led", led, 8'h80);
    chk("coinc_cnt", step_count, 8'd0);
    chk("coinc_wrap", wrap, 1'b0);
    @(negedge clk); tick_slow = 1'b0;
    repeat (2) @(negedge clk);
    chk("coinc_late_led", led, 8'h80);

    // speed_sel toggling with both ticks high
    pause = 1'b1; tick_slow = 1'b1; tick_fast = 1'b1;
    repeat (2) @(negedge clk);
    pause = 1'b0;
    @(negedge clk); speed_sel = 1'b1;
    @(negedge clk); speed_sel = 1'b0;
    @(negedge clk); speed_sel = 1'b1;
    @(negedge clk);
    chk("sel_toggle_led", led, 8'h80);
    chk("sel_toggle_cnt", step_count, 8'd0);
    tick_slow = 1'b0; tick_fast = 1'b0;
    repeat (2) @(negedge clk);
    speed_sel = 1'b0;

    // Reset asserted while a wrap pulse is live
    repeat (7) pulse(1'b0);
    chk("pre_rst_led", led, 8'h01);
    chk("pre_rst_cnt", step_count, 8'd7);
    @(negedge clk); tick_slow = 1'b1;
    @(posedge clk); #1;
    chk("wrap_pulse", wrap, 1'b1);
    chk("wrap_led", led, 8'h80);
    rst = 1'b0; #1;
    chk("async_rst_led", led, 8'h01);
    chk("async_rst_cnt", step_count, 8'd0);
    chk("async_rst_wrap", wrap, 1'b0);
    mode = 2'b00;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("release_led", led, 8'h02);
    chk("release_cnt", step_count, 8'd1);
    tick_slow = 1'b0;
    repeat (2) @(negedge clk);
    chk("release_hold_led", led, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
